// File: rtl/adc_run_sequencer.sv
// adc_run_sequencer
//   Run controller between the software register block and the ADC
//   trigger/packetiser core. A start pulse latches the run configuration,
//   pulses the core's trigger clear, waits a holdoff, then forwards whole
//   packets from the core's AXI-Stream output. A run stops on a packet
//   count, a RUN-state timeout or an abort, and always closes on a packet
//   boundary.
//
//   Build option: define ADC_SEQ_STATS_EN to synthesise the forwarded and
//   dropped word counters. Without it, words_fwd and words_drop read 0.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   cfg_start, cfg_abort    run control pulses
//   cfg_packets             packets per run (0 = unlimited)
//   cfg_timeout             RUN-state cycle limit (0 = none)
//   cfg_holdoff             cycles between trigger release and RUN (0 acts as 1)
//   cfg_limiter/_level      passed to the ADC core, latched at start
//   adc_reset_trigger       active-low trigger clear, low for CLEAR_CYCLES
//   adc_limiter/_level      latched copies of the configuration
//   s_axis_*                ADC core stream (no backpressure)
//   m_axis_*                gated stream, one registered cycle behind s_axis
//   busy, done              run in progress / one-cycle end pulse
//   timed_out, aborted      cause of the last run's end, sticky until start
//   packets_done            packets forwarded in the current/last run
//   words_fwd, words_drop   optional word statistics
module adc_run_sequencer #(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [CNT_WIDTH-1:0] cfg_packets,
  input  logic [CNT_WIDTH-1:0] cfg_timeout,
  input  logic [15:0]          cfg_holdoff,
  input  logic [7:0]           cfg_limiter,
  input  logic [15:0]          cfg_trigger_level,
  output logic                 adc_reset_trigger,
  output logic [7:0]           adc_limiter,
  output logic [15:0]          adc_trigger_level,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic [31:0]          s_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic [31:0]          m_axis_tdata,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] packets_done,
  output logic [31:0]          words_fwd,
  output logic [31:0]          words_drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HOLDOFF, S_RUN, S_DRAIN, S_DONE
  } state_e;

  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_e                 state_q;
  logic [CLR_W-1:0]       clr_q;
  logic [15:0]            hold_q;
  logic [CNT_WIDTH-1:0]   tmo_q;
  logic [CNT_WIDTH-1:0]   pkts_tgt_q, tmo_lim_q, pkts_q;
  logic [15:0]            holdoff_q, lvl_q;
  logic [7:0]             lim_q;
  logic                   rst_trig_q, in_pkt_q, fwd_pkt_q;
  logic                   m_valid_q, m_last_q;
  logic [31:0]            m_data_q;
  logic                   busy_q, done_q, timed_out_q, aborted_q;

  logic                   fwd_d, pkt_end_d, tgt_hit_d, tmo_hit_d;
  logic [CNT_WIDTH-1:0]   pkts_inc_d;

  // A word is forwarded only if its packet began while in RUN; a packet
  // already in flight at RUN entry is dropped through to its tlast, and
  // DRAIN never admits a new packet.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    fwd_d = 1'b0;
    if (s_axis_tvalid) begin
      if (in_pkt_q) fwd_d = fwd_pkt_q && (state_q == S_RUN || state_q == S_DRAIN);
      else          fwd_d = (state_q == S_RUN);
    end
    pkt_end_d  = fwd_d && s_axis_tlast;
    pkts_inc_d = sat_inc(pkts_q);
    tgt_hit_d  = pkt_end_d && (pkts_tgt_q != '0) && (pkts_inc_d == pkts_tgt_q);
    tmo_hit_d  = (tmo_lim_q != '0) && (tmo_q == tmo_lim_q);
  end

  always_ff @(posedge aclk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (areset) begin
      state_q     <= S_IDLE;
      clr_q       <= '0;
      hold_q      <= '0;
      tmo_q       <= '0;
      pkts_tgt_q  <= '0;
      tmo_lim_q   <= '0;
      pkts_q      <= '0;
      holdoff_q   <= '0;
      lim_q       <= '0;
      lvl_q       <= 16'hFFFF;
      rst_trig_q  <= 1'b1;
      in_pkt_q    <= 1'b0;
      fwd_pkt_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      // Packet tracking runs in every state so RUN entry knows whether it
      // lands mid-packet.
      if (s_axis_tvalid) begin
        in_pkt_q <= !s_axis_tlast;
        if (!in_pkt_q) fwd_pkt_q <= (state_q == S_RUN);
      end

      m_valid_q <= fwd_d;
      m_last_q  <= pkt_end_d;
      if (fwd_d) m_data_q <= s_axis_tdata;
      if (pkt_end_d) pkts_q <= pkts_inc_d;

      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            state_q     <= S_CLEAR;
            pkts_tgt_q  <= cfg_packets;
            tmo_lim_q   <= cfg_timeout;
            holdoff_q   <= cfg_holdoff;
            lim_q       <= cfg_limiter;
            lvl_q       <= cfg_trigger_level;
            pkts_q      <= '0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            rst_trig_q  <= 1'b0;
            clr_q       <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cfg_abort) begin
            state_q    <= S_DONE;
            rst_trig_q <= 1'b1;
            aborted_q  <= 1'b1;
            done_q     <= 1'b1;
          end else if (clr_q == CLR_LAST) begin
            state_q    <= S_HOLDOFF;
            rst_trig_q <= 1'b1;
            hold_q     <= '0;
          end else begin
            clr_q <= clr_q + CLR_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (cfg_abort) begin
            state_q   <= S_DONE;
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
          end else if ({1'b0, hold_q} + 17'd1 >= {1'b0, holdoff_q}) begin
            // A holdoff of 0 still spends one cycle here.
            state_q <= S_RUN;
            tmo_q   <= CNT_WIDTH'(1);
          end else begin
            hold_q <= hold_q + 16'd1;
          end
        end
        S_RUN: begin
          // tmo_q holds the 1-based index of the current RUN cycle.
          tmo_q <= sat_inc(tmo_q);
          if (tgt_hit_d) begin
            state_q <= S_DRAIN;
          end else if (cfg_abort) begin
            state_q   <= S_DRAIN;
            aborted_q <= 1'b1;
          end else if (tmo_hit_d) begin
            state_q     <= S_DRAIN;
            timed_out_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!(in_pkt_q && fwd_pkt_q) || pkt_end_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_reset_trigger = rst_trig_q;
  assign adc_limiter       = lim_q;
  assign adc_trigger_level = lvl_q;
  assign m_axis_tvalid     = m_valid_q;
  assign m_axis_tlast      = m_last_q;
  assign m_axis_tdata      = m_data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timed_out         = timed_out_q;
  assign aborted           = aborted_q;
  assign packets_done      = pkts_q;

`ifdef ADC_SEQ_STATS_EN
  logic [31:0] words_fwd_q, words_drop_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      words_fwd_q  <= '0;
      words_drop_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (cfg_start) begin
        words_fwd_q  <= '0;
        words_drop_q <= '0;
      end
    end else if (fwd_d) begin
      if (words_fwd_q != '1) words_fwd_q <= words_fwd_q + 32'd1;
    end else if (s_axis_tvalid) begin
      if (words_drop_q != '1) words_drop_q <= words_drop_q + 32'd1;
    end
  end

  assign words_fwd  = words_fwd_q;
  assign words_drop = words_drop_q;
`else
  assign words_fwd  = '0;
  assign words_drop = '0;
`endif

endmodule

// File: tb/tb_adc_run_sequencer.sv
// Testbench for adc_run_sequencer: directed scenarios with hand-computed
// expectations plus randomized runs, all compared every cycle against a
// behavioural model that tracks time since start and packet ownership.
module tb_adc_run_sequencer;

  localparam int unsigned CW  = 32;
  localparam int unsigned CLR = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_start, cfg_abort;
  logic [CW-1:0] cfg_packets, cfg_timeout;
  logic [15:0]   cfg_holdoff, cfg_trigger_level;
  logic [7:0]    cfg_limiter;
  logic          adc_reset_trigger;
  logic [7:0]    adc_limiter;
  logic [15:0]   adc_trigger_level;
  logic          s_axis_tvalid, s_axis_tlast;
  logic [31:0]   s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic [31:0]   m_axis_tdata;
  logic          busy, done, timed_out, aborted;
  logic [CW-1:0] packets_done;
  logic [31:0]   words_fwd, words_drop;

  adc_run_sequencer #(.CNT_WIDTH(CW), .CLEAR_CYCLES(CLR)) dut (
    .aclk(aclk), .areset(areset),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_packets(cfg_packets), .cfg_timeout(cfg_timeout),
    .cfg_holdoff(cfg_holdoff), .cfg_limiter(cfg_limiter),
    .cfg_trigger_level(cfg_trigger_level),
    .adc_reset_trigger(adc_reset_trigger), .adc_limiter(adc_limiter),
    .adc_trigger_level(adc_trigger_level),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .busy(busy), .done(done), .timed_out(timed_out), .aborted(aborted),
    .packets_done(packets_done), .words_fwd(words_fwd), .words_drop(words_drop)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned sat32(input longint unsigned v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // ---------------------------------------------------------------------
  // Behavioural model: a run is a timeline counted from the start edge
  // (CLR clear cycles, then max(holdoff,1) holdoff cycles, then RUN) plus
  // "ending" (draining) and "closing" (done cycle) flags.
  // ---------------------------------------------------------------------
  bit              md_act, md_ending, md_closing;
  int unsigned     md_since;
  longint unsigned md_tgt, md_tmo;
  int unsigned     md_hold;
  bit [7:0]        md_lim;
  bit [15:0]       md_lvl;
  bit              md_open, md_own;
  longint unsigned md_pk, md_wf, md_wd;
  bit              md_to, md_ab;
  bit              md_v, md_l;
  bit [31:0]       md_d;

  always @(posedge aclk) begin : model
    bit fwd, act_pre, c_clr, c_hold, c_run, c_drain, word_end;
    int unsigned hn;
    if (areset) begin
      md_act = 0; md_ending = 0; md_closing = 0; md_since = 0;
      md_tgt = 0; md_tmo = 0; md_hold = 0; md_lim = 0; md_lvl = 16'hFFFF;
      md_open = 0; md_own = 0; md_pk = 0; md_wf = 0; md_wd = 0;
      md_to = 0; md_ab = 0; md_v = 0; md_l = 0; md_d = 0;
    end else begin
      hn      = (md_hold == 0) ? 1 : md_hold;
      act_pre = md_act;
      c_clr   = md_act && !md_closing && !md_ending && md_since >= 1 && md_since <= CLR;
      c_hold  = md_act && !md_closing && !md_ending && md_since > CLR && md_since <= CLR + hn;
      c_run   = md_act && !md_closing && !md_ending && md_since > CLR + hn;
      c_drain = md_act && !md_closing && md_ending;

      fwd = 0;
      if (s_axis_tvalid) fwd = md_open ? (md_own && (c_run || c_drain)) : c_run;
      word_end = fwd && s_axis_tlast;

      if (!md_act) begin
        if (cfg_start) begin
          md_act = 1; md_since = 1; md_ending = 0; md_closing = 0;
          md_tgt = cfg_packets; md_tmo = cfg_timeout; md_hold = cfg_holdoff;
          md_lim = cfg_limiter; md_lvl = cfg_trigger_level;
          md_pk = 0; md_to = 0; md_ab = 0; md_wf = 0; md_wd = 0;
        end
      end else if (md_closing) begin
        md_act = 0; md_closing = 0; md_ending = 0;
      end else if (c_clr || c_hold) begin
        if (cfg_abort) begin md_closing = 1; md_ab = 1; end
      end else if (c_run) begin
        if (word_end) md_pk = sat32(md_pk);
        if (word_end && md_tgt != 0 && md_pk == md_tgt) md_ending = 1;
        else if (cfg_abort) begin md_ending = 1; md_ab = 1; end
        else if (md_tmo != 0 && longint'(md_since - CLR - hn) == md_tmo) begin
          md_ending = 1; md_to = 1;
        end
      end else begin
        if (word_end) md_pk = sat32(md_pk);
        if (!(md_open && md_own) || word_end) md_closing = 1;
      end
      if (act_pre) md_since++;

      if (act_pre) begin
        if (fwd) md_wf = sat32(md_wf);
        else if (s_axis_tvalid) md_wd = sat32(md_wd);
      end

      if (s_axis_tvalid) begin
        if (!md_open) md_own = c_run;
        md_open = !s_axis_tlast;
      end

      md_v = fwd;
      md_l = word_end;
      if (fwd) md_d = s_axis_tdata;
    end
  end

  // Single compare process, every cycle away from the active edge.
  always @(negedge aclk) begin
    if (cmp_en) begin
      check("m_tvalid", m_axis_tvalid, md_v);
      check("m_tlast", m_axis_tlast, md_l);
      check("m_tdata", m_axis_tdata, md_d);
      check("adc_reset_trigger", adc_reset_trigger,
            !(md_act && !md_closing && !md_ending && md_since >= 1 && md_since <= CLR));
      check("adc_limiter", adc_limiter, md_lim);
      check("adc_trigger_level", adc_trigger_level, md_lvl);
      check("busy", busy, md_act);
      check("done", done, md_closing);
      check("timed_out", timed_out, md_to);
      check("aborted", aborted, md_ab);
      check("packets_done", packets_done, md_pk);
`ifdef ADC_SEQ_STATS_EN
      check("words_fwd", words_fwd, md_wf);
      check("words_drop", words_drop, md_wd);
`else
      check("words_fwd", words_fwd, 0);
      check("words_drop", words_drop, 0);
`endif
    end
  end

  // Independent event counters used by the hand-computed checks.
  int mon_fwd = 0, mon_low = 0, mon_done = 0, done_run = 0, done_max = 0;
  always @(negedge aclk) begin
    if (m_axis_tvalid) mon_fwd++;
    if (!adc_reset_trigger) mon_low++;
    if (done) begin
      mon_done++;
      done_run++;
      if (done_run > done_max) done_max = done_run;
    end else begin
      done_run = 0;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the active edge.
  // ---------------------------------------------------------------------
  int unsigned rem = 0, gap_left = 0;

  task automatic drive(input bit v, input bit l, input bit st, input bit ab);
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    s_axis_tdata  = $urandom();
    cfg_start     = st;
    cfg_abort     = ab;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++) drive(1, i == len - 1, 0, 0);
  endtask

  task automatic set_cfg(input int unsigned pk, input int unsigned tmo, input int unsigned hold,
                         input bit [7:0] lim, input bit [15:0] lvl);
    cfg_packets       = pk;
    cfg_timeout       = tmo;
    cfg_holdoff       = 16'(hold);
    cfg_limiter       = lim;
    cfg_trigger_level = lvl;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) drive(0, 0, 0, 0);
    check(name, busy, 0);
  endtask

  task automatic rnd_cycle(input bit st, input bit ab);
    bit v, l;
    v = 0; l = 0;
    if (gap_left > 0) begin
      gap_left--;
    end else begin
      if (rem == 0) rem = $urandom_range(1, 8);
      v = 1;
      rem--;
      l = (rem == 0);
      if (l) gap_left = $urandom_range(0, 3);
    end
    drive(v, l, st, ab);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int f0, l0, d0;
    areset = 1;
    set_cfg(0, 0, 0, 8'h00, 16'h0000);
    drive(0, 0, 0, 0);
    cmp_en = 1;
    drive(0, 0, 0, 0);
    check("rst_trigger", adc_reset_trigger, 1);
    check("rst_level", adc_trigger_level, 16'hFFFF);
    check("rst_busy", busy, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    areset = 0;
    idle(2);

    // Basic run; abort alongside start in IDLE must be ignored.
    set_cfg(2, 0, 3, 8'h5A, 16'h1234);
    f0 = mon_fwd; l0 = mon_low; d0 = mon_done;
    drive(0, 0, 1, 1);
    set_cfg(7, 3, 9, 8'hA5, 16'h4321);   // mid-run changes have no effect
    idle(7);
    repeat (3) send_pkt(4);
    wait_idle("basic_end", 50);
    idle(2);
    check("basic_fwd_words", mon_fwd - f0, 8);
    check("basic_clear_cycles", mon_low - l0, 4);
    check("basic_done_pulses", mon_done - d0, 1);
    check("basic_packets", packets_done, 2);
    check("basic_limiter", adc_limiter, 8'h5A);
    check("basic_level", adc_trigger_level, 16'h1234);
    check("basic_aborted", aborted, 0);

    // Packet in flight at RUN entry is dropped; the next one is forwarded.
    set_cfg(1, 0, 3, 8'h11, 16'h0100);
    f0 = mon_fwd;
    drive(0, 0, 1, 0);
    idle(5);
    send_pkt(6);
    send_pkt(4);
    wait_idle("midpkt_end", 50);
    idle(1);
    check("midpkt_fwd_words", mon_fwd - f0, 4);
    check("midpkt_packets", packets_done, 1);
`ifdef ADC_SEQ_STATS_EN
    check("midpkt_words_drop", words_drop, 6);
    check("midpkt_words_fwd", words_fwd, 4);
`else
    check("midpkt_words_drop", words_drop, 0);
`endif

    // Timeout at RUN cycle 10 while a packet that began at cycle 7 is open.
    set_cfg(0, 10, 0, 8'h22, 16'h0200);
    f0 = mon_fwd;
    drive(0, 0, 1, 0);
    idle(11);
    send_pkt(8);
    wait_idle("timeout_end", 50);
    idle(1);
    check("timeout_fwd_words", mon_fwd - f0, 8);
    check("timeout_flag", timed_out, 1);
    check("timeout_aborted", aborted, 0);
    check("timeout_packets", packets_done, 1);

    // Abort on the first holdoff cycle.
    set_cfg(0, 0, 5, 8'h33, 16'h0300);
    f0 = mon_fwd;
    drive(0, 0, 1, 0);
    idle(4);
    drive(1, 0, 0, 1);
    check("hold_abort_done", done, 1);
    check("hold_abort_flag", aborted, 1);
    check("hold_abort_trigger", adc_reset_trigger, 1);
    drive(1, 1, 0, 0);
    check("hold_abort_idle", busy, 0);
    idle(1);
    check("hold_abort_fwd_words", mon_fwd - f0, 0);

    // Target tlast, abort and timeout all in RUN cycle 4: target wins.
    set_cfg(1, 4, 0, 8'h44, 16'h0400);
    drive(0, 0, 1, 0);
    idle(5);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 1);
    wait_idle("collide_end", 20);
    check("collide_timed_out", timed_out, 0);
    check("collide_aborted", aborted, 0);
    check("collide_packets", packets_done, 1);

    // Reset while draining, then a normal run.
    set_cfg(0, 3, 0, 8'h55, 16'h0500);
    drive(0, 0, 1, 0);
    idle(6);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        check("drain_timed_out", timed_out, 1);
        areset = 1;
      end
      drive(1, i == 7, 0, 0);
      if (i == 3) begin
        areset = 0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_trigger", adc_reset_trigger, 1);
        check("rst_mid_level", adc_trigger_level, 16'hFFFF);
        check("rst_mid_limiter", adc_limiter, 0);
        check("rst_mid_m_tvalid", m_axis_tvalid, 0);
        check("rst_mid_m_tdata", m_axis_tdata, 0);
        check("rst_mid_timed_out", timed_out, 0);
        check("rst_mid_packets", packets_done, 0);
      end
    end
    set_cfg(1, 0, 2, 8'h66, 16'h0600);
    f0 = mon_fwd;
    drive(0, 0, 1, 0);
    idle(6);
    send_pkt(3);
    wait_idle("post_rst_end", 20);
    idle(1);
    check("post_rst_packets", packets_done, 1);
    check("post_rst_fwd_words", mon_fwd - f0, 3);

    // Randomized runs against the model.
    rem = 0; gap_left = 0;
    for (int r = 0; r < 40; r++) begin
      set_cfg($urandom_range(0, 4),
              ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 60),
              $urandom_range(0, 6), 8'($urandom()), 16'($urandom()));
      rnd_cycle(1, 0);
      for (int c = 0; c < 400 && busy; c++) begin
        rnd_cycle($urandom_range(0, 15) == 0, (c > 150) || ($urandom_range(0, 79) == 0));
        if ($urandom_range(0, 7) == 0) cfg_limiter = 8'($urandom());
      end
      check("rnd_run_end", busy, 0);
      repeat ($urandom_range(1, 5)) rnd_cycle(0, 0);
    end

    idle(2);
    check("done_width", done_max, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
